// File: rtl/dmem_resp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dmem_resp
// Purpose  : Data-SRAM responder with byte-lane writes. Define
//            DMEM_RESP_WAITSTATE_EN to add the wait-state FSM and stall.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_resp #(
   parameter int DEPTH_LOG2  = 12,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_en,
   input  logic [3:0]  req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic [31:0] rsp_rdata,
   output logic        rsp_valid,
   output logic        rsp_stall
);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [31:0]           store_q [DEPTH];
   logic [31:0]           rdata_q, rdata_d;
   logic                  valid_q, valid_d;
   logic                  commit_en;
   logic [3:0]            commit_wen;
   logic [DEPTH_LOG2-1:0] commit_idx;
   logic [31:0]           commit_wdata;
   logic [DEPTH_LOG2-1:0] req_idx;
   logic                  unused_addr_bits;

   // Low two bits and bits above the store range alias away.
   assign req_idx          = req_addr[DEPTH_LOG2+1:2];
   assign unused_addr_bits = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};

`ifdef DMEM_RESP_WAITSTATE_EN
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  stall_q, stall_d;
   logic [3:0]            cap_wen_q, cap_wen_d;
   logic [DEPTH_LOG2-1:0] cap_idx_q, cap_idx_d;
   logic [31:0]           cap_wdata_q, cap_wdata_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      stall_d     = 1'b0;
      valid_d     = 1'b0;
      commit_en   = 1'b0;
      cap_wen_d   = cap_wen_q;
      cap_idx_d   = cap_idx_q;
      cap_wdata_d = cap_wdata_q;
      case (state_q)
         S_IDLE: begin
            if (req_en) begin
               cap_wen_d   = req_wen;
               cap_idx_d   = req_idx;
               cap_wdata_d = req_wdata;
               cnt_d       = 4'(WAIT_CYCLES);
               stall_d     = 1'b1;
               state_d     = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               commit_en = 1'b1;
               valid_d   = 1'b1;
               state_d   = S_RESP;
            end else begin
               cnt_d   = cnt_q - 4'd1;
               stall_d = 1'b1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign commit_wen   = cap_wen_q;
   assign commit_idx   = cap_idx_q;
   assign commit_wdata = cap_wdata_q;
   // First stall cycle must be combinational so the pipeline holds the request.
   assign rsp_stall    = stall_q | ((state_q == S_IDLE) & req_en);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         stall_q     <= 1'b0;
         cap_wen_q   <= 4'd0;
         cap_idx_q   <= '0;
         cap_wdata_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_q     <= stall_d;
         cap_wen_q   <= cap_wen_d;
         cap_idx_q   <= cap_idx_d;
         cap_wdata_q <= cap_wdata_d;
      end
   end
`else
   logic [3:0] unused_wait_cycles;

   assign unused_wait_cycles = 4'(WAIT_CYCLES);
   assign commit_en          = req_en;
   assign commit_wen         = req_wen;
   assign commit_idx         = req_idx;
   assign commit_wdata       = req_wdata;
   assign valid_d            = req_en;
   assign rsp_stall          = 1'b0;
`endif

   always_comb begin
      rdata_d = rdata_q;
      if (commit_en && (commit_wen == 4'd0)) begin
         rdata_d = store_q[commit_idx];
      end
   end

   // Store has no reset; only the commit is suppressed while rst is high.
   always_ff @(posedge clk) begin
      if (!rst && commit_en) begin
         for (int i = 0; i < 4; i++) begin
            if (commit_wen[i]) begin
               store_q[commit_idx][8*i +: 8] <= commit_wdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= 32'd0;
         valid_q <= 1'b0;
      end else begin
         rdata_q <= rdata_d;
         valid_q <= valid_d;
      end
   end

   assign rsp_rdata = rdata_q;
   assign rsp_valid = valid_q;
endmodule
`default_nettype wire

// File: tb/tb_dmem_resp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dmem_resp
// Purpose  : Randomized self-checking bench for dmem_resp against a
//            transaction-level model (latency/period arithmetic + word map).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_resp;
   localparam int DL2  = 12;
   localparam int W    = 2;
   localparam int MAXC = 6000;
`ifdef DMEM_RESP_WAITSTATE_EN
   localparam bit WS  = 1'b1;
   localparam int LAT = W + 2;
   localparam int PER = W + 3;
`else
   localparam bit WS  = 1'b0;
   localparam int LAT = 1;
   localparam int PER = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_en = 1'b0;
   logic [3:0]  req_wen = 4'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic [31:0] rsp_rdata;
   logic        rsp_valid;
   logic        rsp_stall;

   dmem_resp #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_en    (req_en),
      .req_wen   (req_wen),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_rdata (rsp_rdata),
      .rsp_valid (rsp_valid),
      .rsp_stall (rsp_stall)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   bit          exp_valid  [MAXC];
   bit          exp_stall  [MAXC];
   bit          exp_rd_set [MAXC];
   logic [31:0] exp_rd_val [MAXC];
   bit          lit_en     [MAXC];
   logic [31:0] lit_val    [MAXC];
   int          lit_id     [MAXC];
   logic [31:0] mdl [int];

   function automatic logic [31:0] model_read(input int i);
      return mdl.exists(i) ? mdl[i] : 32'd0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      req_en = 1'b0;
      repeat (n) step();
   endtask

   task automatic lit(input int c, input logic [31:0] v, input int id);
      lit_en[c]  = 1'b1;
      lit_val[c] = v;
      lit_id[c]  = id;
   endtask

   // Presents one request, updates the model, schedules the expected response.
   task automatic issue(input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] data, input bit scramble, output int rsp_c);
      int          c;
      int          i;
      logic [31:0] tmp;
      c = cyc;
      i = int'(addr[DL2+1:2]);
      if (c + LAT + PER + 2 >= MAXC) begin
         $display("FAIL schedule_overflow cyc=%0d got=%0d want<%0d", c, c + LAT, MAXC);
         errors++;
         $fatal(1, "schedule overflow");
      end
      req_en    = 1'b1;
      req_wen   = wen;
      req_addr  = addr;
      req_wdata = data;
      if (wen != 4'd0) begin
         tmp = model_read(i);
         for (int b = 0; b < 4; b++) if (wen[b]) tmp[8*b +: 8] = data[8*b +: 8];
         mdl[i] = tmp;
      end else begin
         exp_rd_set[c + LAT] = 1'b1;
         exp_rd_val[c + LAT] = model_read(i);
      end
      exp_valid[c + LAT] = 1'b1;
      if (WS) for (int k = 0; k <= W + 1; k++) exp_stall[c + k] = 1'b1;
      rsp_c = c + LAT;
      for (int k = 0; k < PER; k++) begin
         step();
         if (WS && scramble && k < W + 1) begin
            req_addr  = $urandom;
            req_wdata = $urandom;
            req_wen   = 4'($urandom_range(1, 15));
         end
      end
   endtask

   // Per-cycle compare against the model's schedule.
   logic [31:0] cur_rdata = 32'd0;
   bit          rst_pending = 1'b0;
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            rst_pending = 1'b1;
         end else begin
            if (rst_pending) begin
               cur_rdata   = 32'd0;
               rst_pending = 1'b0;
            end
            if (exp_rd_set[cyc]) cur_rdata = exp_rd_val[cyc];
            chk("valid", {31'd0, rsp_valid}, {31'd0, exp_valid[cyc]});
            chk("stall", {31'd0, rsp_stall}, {31'd0, exp_stall[cyc]});
            chk("rdata", rsp_rdata, cur_rdata);
            if (lit_en[cyc]) begin
               checks++;
               if (rsp_rdata !== lit_val[cyc]) begin
                  errors++;
                  $display("FAIL lit%0d cyc=%0d got=%h want=%h", lit_id[cyc], cyc, rsp_rdata, lit_val[cyc]);
               end
            end
         end
      end
   end

   initial begin
      #(MAXC * 10 + 1000);
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      logic [3:0]  wen;
      logic [31:0] addr;
      repeat (3) step();
      rst = 1'b0;
      lit(cyc, 32'd0, 0);

      for (int w = 0; w < 8; w++) issue(4'hF, 32'h200 + 32'(w * 4), 32'd0, 1'b0, r);

      issue(4'hF, 32'h100, 32'hDEADBEEF, 1'b0, r);
      issue(4'h0, 32'h100, 32'd0, 1'b0, r);
      lit(r, 32'hDEADBEEF, 1);

      issue(4'hF, 32'h104, 32'h11223344, 1'b0, r);
      issue(4'h5, 32'h104, 32'hAABBCCDD, 1'b0, r);
      issue(4'h0, 32'h104, 32'd0, 1'b0, r);
      lit(r, 32'h11BB33DD, 2);

      issue(4'hF, 32'h0000_0010, 32'hCAFE0001, 1'b0, r);
      issue(4'h0, 32'h0000_4010, 32'd0, 1'b0, r);
      lit(r, 32'hCAFE0001, 3);

      issue(4'hF, 32'h300, 32'h55AA55AA, 1'b1, r);
      issue(4'h0, 32'h300, 32'd0, 1'b0, r);
      lit(r, 32'h55AA55AA, 4);

      issue(4'hF, 32'h400, 32'h0BADF00D, 1'b0, r);
      issue(4'h0, 32'h400, 32'd0, 1'b0, r);
      lit(r, 32'h0BADF00D, 5);
`ifdef DMEM_RESP_WAITSTATE_EN
      // Write abandoned by reset while the counter reads 1.
      r = cyc;
      req_en = 1'b1; req_wen = 4'hF; req_addr = 32'h400; req_wdata = 32'h12345678;
      for (int k = 0; k <= W; k++) exp_stall[r + k] = 1'b1;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      req_en = 1'b0;
      lit(cyc, 32'd0, 6);
      step();
`else
      idle(1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      lit(cyc, 32'd0, 6);
      step();
`endif
      issue(4'h0, 32'h400, 32'd0, 1'b0, r);
      lit(r, 32'h0BADF00D, 7);

      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            idle($urandom_range(1, 2));
         end else begin
            wen  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            addr = ($urandom & 32'hFFFF_C003) | (32'h200 + 32'($urandom_range(0, 7) * 4));
            issue(wen, addr, $urandom, $urandom_range(0, 3) == 0, r);
         end
      end
      idle(PER + 2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
